// File: rtl/float_rcp_pkg.sv
// Shared types and constants for the shared float reciprocal path (E8_M23 operands, 37-bit result).
package float_rcp_pkg;

    localparam int RCP_X_W   = 37;
    localparam int RCP_EXP_W = 8;
    localparam int RCP_MAN_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [RCP_EXP_W-1:0] exp;
        logic [RCP_MAN_W-1:0] man;
    } rcp_operand_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/float_rcp_pipe.sv
// Stall-gated float reciprocal pipe: x = {sign, exp, 28-bit fraction}, LAT register (rreg) stages.
// Exponent is computed modulo 256; zero/denormal/inf/NaN operands get no special treatment.
module float_rcp_pipe
    import float_rcp_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic                 aclk,
    input  logic                 astall,
    input  logic                 a_sign,
    input  logic [RCP_EXP_W-1:0] a_exp,
    input  logic [RCP_MAN_W-1:0] a_man,
    output logic [RCP_X_W-1:0]   x
);

    logic [27:0]        frac_s;
    logic [RCP_X_W-1:0] x_s;
    logic [RCP_X_W-1:0] rreg_d [LAT];
    logic [RCP_X_W-1:0] rreg_q [LAT];

    // 1/(1.m) lies in (0.5,1]; 2^52/{1,m} yields its normalised mantissa scaled by 2^28
    always_comb begin
        frac_s = 28'(53'h10000000000000 / {29'd0, 1'b1, a_man});
        if (a_man == 23'd0) begin
            x_s = {a_sign, 8'd254 - a_exp, 28'd0};
        end else begin
            x_s = {a_sign, 8'd253 - a_exp, frac_s};
        end
    end

    // Register chain advances only when the pipe is not stalled
    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            if (astall) begin
                rreg_d[k] = rreg_q[k];
            end else if (k == 0) begin
                rreg_d[k] = x_s;
            end else begin
                rreg_d[k] = rreg_q[k-1];
            end
        end
    end

    // Data registers are intentionally not reset
    always_ff @(posedge aclk) begin
        rreg_q <= rreg_d;
    end

    assign x = rreg_q[LAT-1];

endmodule

// File: rtl/float_rcp_rr_arb.sv
// Round-robin arbiter: first request at or above ptr (wrapping) wins; next_ptr points past the winner.
module float_rcp_rr_arb
    import float_rcp_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic          enable,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] next_ptr
);

    int   idx;
    logic found;

    // Scan N positions starting at ptr
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PW'((idx + 1) % N);
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/float_rcp_share_ctrl.sv
// Shares one reciprocal pipe among NUM_REQ requesters with round-robin grant and ID tracking.
// Optional perf counters behind FLOAT_RCP_SHARE_PERF_EN.
module float_rcp_share_ctrl
    import float_rcp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int RCP_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                           aclk,
    input  logic                           arst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_sign,
    input  logic [NUM_REQ*RCP_EXP_W-1:0]   req_exp,
    input  logic [NUM_REQ*RCP_MAN_W-1:0]   req_man,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [RCP_X_W-1:0]             rsp_x,
    output logic                           busy
`ifdef FLOAT_RCP_SHARE_PERF_EN
   ,output logic [31:0]                    perf_issue,
    output logic [31:0]                    perf_stall,
    output logic [31:0]                    perf_conflict
`endif
);

    localparam int HEAD = RCP_LAT - 1;

    logic [RCP_LAT-1:0] vld_d, vld_q;
    logic [ID_W-1:0]    id_d [RCP_LAT];
    logic [ID_W-1:0]    id_q [RCP_LAT];
    logic [ID_W-1:0]    rr_ptr_d, rr_ptr_q;
    logic [ID_W-1:0]    next_ptr_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               grant_any_s;
    logic               head_rdy_s;
    logic               stall_s;
    logic               arb_en_s;
    rcp_operand_t       a_op_s;

    // Head stall: result waiting and its owner not accepting; reset masks everything
    always_comb begin
        head_rdy_s = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (id_q[HEAD] == ID_W'(j)) begin
                head_rdy_s = rsp_ready[j];
            end else begin
                head_rdy_s = head_rdy_s;
            end
        end
        stall_s  = vld_q[HEAD] & ~head_rdy_s & ~arst;
        arb_en_s = ~stall_s & ~arst;
    end

    float_rcp_rr_arb #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_arb (
        .req      (req_valid),
        .enable   (arb_en_s),
        .ptr      (rr_ptr_q),
        .grant    (grant_s),
        .next_ptr (next_ptr_s)
    );

    // Encode the grant and mux the winner's operand (zero when idle)
    always_comb begin
        grant_any_s = |grant_s;
        grant_id_s  = '0;
        a_op_s      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                grant_id_s = ID_W'(i);
                a_op_s.sign = req_sign[i];
                a_op_s.exp  = req_exp[RCP_EXP_W*i +: RCP_EXP_W];
                a_op_s.man  = req_man[RCP_MAN_W*i +: RCP_MAN_W];
            end else begin
                grant_id_s = grant_id_s;
            end
        end
    end

    assign req_ready = grant_s;

    // ID/valid tracking advances in lockstep with the pipe data
    always_comb begin
        vld_d    = vld_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (!stall_s) begin
            vld_d[0] = grant_any_s;
            id_d[0]  = grant_id_s;
            for (int k = 1; k < RCP_LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                id_d[k]  = id_q[k-1];
            end
            if (grant_any_s) begin
                rr_ptr_d = next_ptr_s;
            end else begin
                rr_ptr_d = rr_ptr_q;
            end
        end else begin
            vld_d = vld_q;
        end
    end

    // Valid bits and round-robin pointer
    always_ff @(posedge aclk) begin
        if (arst) begin
            vld_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            vld_q    <= vld_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Requester IDs carry no reset; they are qualified by vld_q
    always_ff @(posedge aclk) begin
        id_q <= id_d;
    end

    // Route the head result to its owner
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            rsp_valid[j] = vld_q[HEAD] & (id_q[HEAD] == ID_W'(j)) & ~arst;
        end
        busy = (|vld_q) & ~arst;
    end

    float_rcp_pipe #(
        .LAT (RCP_LAT)
    ) u_pipe (
        .aclk   (aclk),
        .astall (stall_s),
        .a_sign (a_op_s.sign),
        .a_exp  (a_op_s.exp),
        .a_man  (a_op_s.man),
        .x      (rsp_x)
    );

`ifdef FLOAT_RCP_SHARE_PERF_EN
    logic [31:0] perf_issue_d, perf_issue_q;
    logic [31:0] perf_stall_d, perf_stall_q;
    logic [31:0] perf_conflict_d, perf_conflict_q;
    logic        multi_req_s;

    // Saturating event counters
    always_comb begin
        multi_req_s     = (req_valid & (req_valid - NUM_REQ'(1))) != '0;
        perf_issue_d    = perf_issue_q;
        perf_stall_d    = perf_stall_q;
        perf_conflict_d = perf_conflict_q;
        if (grant_any_s && (perf_issue_q != 32'hFFFF_FFFF)) begin
            perf_issue_d = perf_issue_q + 32'd1;
        end else begin
            perf_issue_d = perf_issue_q;
        end
        if (stall_s && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if (grant_any_s && multi_req_s && (perf_conflict_q != 32'hFFFF_FFFF)) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end else begin
            perf_conflict_d = perf_conflict_q;
        end
    end

    // Counter registers
    always_ff @(posedge aclk) begin
        if (arst) begin
            perf_issue_q    <= 32'd0;
            perf_stall_q    <= 32'd0;
            perf_conflict_q <= 32'd0;
        end else begin
            perf_issue_q    <= perf_issue_d;
            perf_stall_q    <= perf_stall_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_issue    = perf_issue_q;
    assign perf_stall    = perf_stall_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_float_rcp_share_ctrl.sv
// Directed bench for float_rcp_share_ctrl with a transaction-level model compared every cycle.
module tb_float_rcp_share_ctrl;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic         aclk = 1'b0;
    logic         arst;
    logic [3:0]   req_valid, req_ready, req_sign, rsp_valid, rsp_ready;
    logic [31:0]  req_exp;
    logic [91:0]  req_man;
    logic [36:0]  rsp_x;
    logic         busy;
`ifdef FLOAT_RCP_SHARE_PERF_EN
    logic [31:0]  perf_issue, perf_stall, perf_conflict;
`endif

    always #5 aclk = ~aclk;

    float_rcp_share_ctrl #(.NUM_REQ(4), .RCP_LAT(1), .ID_W(2)) dut (
        .aclk          (aclk),
        .arst          (arst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_sign      (req_sign),
        .req_exp       (req_exp),
        .req_man       (req_man),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_x         (rsp_x),
        .busy          (busy)
`ifdef FLOAT_RCP_SHARE_PERF_EN
       ,.perf_issue    (perf_issue),
        .perf_stall    (perf_stall),
        .perf_conflict (perf_conflict)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reciprocal from first principles: 1/(2^e * (1+f)) renormalised to a 28-bit fraction
    function automatic logic [36:0] rcp_ref(input logic s, input logic [7:0] e, input logic [22:0] m);
        logic [63:0] q;
        logic [7:0]  be;
        if (m == 23'd0) begin
            be = 8'(254 - int'(e));
            return {s, be, 28'd0};
        end
        q  = (64'd1 << 52) / (64'd8388608 + 64'(m));
        be = 8'(253 - int'(e));
        return {s, be, 28'(q - (64'd1 << 28))};
    endfunction

    // Operand updates are staged and applied together with the next cycle's controls
    logic [3:0]  nxt_sign;
    logic [31:0] nxt_exp;
    logic [91:0] nxt_man;

    task automatic set_op(input int i, input logic s, input logic [7:0] e, input logic [22:0] m);
        nxt_sign[i]         = s;
        nxt_exp[8*i +: 8]   = e;
        nxt_man[23*i +: 23] = m;
    endtask

    task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] rdy);
        @(posedge aclk);
        #1;
        arst      = r;
        req_valid = v;
        rsp_ready = rdy;
        req_sign  = nxt_sign;
        req_exp   = nxt_exp;
        req_man   = nxt_man;
        @(negedge aclk);
    endtask

    // Model: queue of in-flight operations in grant order, each with its unstalled age
    int          m_id[$];
    logic [36:0] m_x[$];
    int          m_age[$];
    int          m_ptr = 0;
    int          m_iss = 0, m_stl = 0, m_cfl = 0;
    bit          m_known = 1'b0;

    always @(negedge aclk) begin : cmp
        logic [3:0] e_ready, e_rsp;
        logic       e_stall;
        int         g, idx;
`ifdef FLOAT_RCP_SHARE_PERF_EN
        if (m_known) begin
            chk("perf_issue", 64'(perf_issue), 64'(m_iss));
            chk("perf_stall", 64'(perf_stall), 64'(m_stl));
            chk("perf_conflict", 64'(perf_conflict), 64'(m_cfl));
        end
`endif
        e_ready = 4'd0;
        e_rsp   = 4'd0;
        e_stall = 1'b0;
        g       = -1;
        if (!arst) begin
            if (m_id.size() > 0 && m_age[0] == LAT) begin
                e_rsp[m_id[0]] = 1'b1;
                e_stall        = !rsp_ready[m_id[0]];
            end
            if (!e_stall) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) e_ready[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(e_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        chk("busy", 64'(busy), 64'(!arst && m_id.size() > 0));
        chk("astall", 64'(dut.stall_s), 64'(e_stall));
        if (e_rsp != 4'd0) chk("rsp_x", 64'(rsp_x), 64'(m_x[0]));

        if (arst) begin
            m_id.delete();
            m_x.delete();
            m_age.delete();
            m_ptr   = 0;
            m_iss   = 0;
            m_stl   = 0;
            m_cfl   = 0;
            m_known = 1'b1;
        end else if (e_stall) begin
            m_stl++;
        end else begin
            if (e_rsp != 4'd0) begin
                void'(m_id.pop_front());
                void'(m_x.pop_front());
                void'(m_age.pop_front());
            end
            foreach (m_age[i]) m_age[i]++;
            if (g >= 0) begin
                m_id.push_back(g);
                m_x.push_back(rcp_ref(req_sign[g], req_exp[8*g +: 8], req_man[23*g +: 23]));
                m_age.push_back(1);
                m_ptr = (g + 1) % N;
                m_iss++;
                if ($countones(req_valid) > 1) m_cfl++;
            end
        end
    end

    logic [36:0] held_x;

    initial begin
        arst      = 1'b1;
        req_valid = 4'd0;
        rsp_ready = 4'hF;
        nxt_sign  = 4'd0;
        nxt_exp   = 32'd0;
        nxt_man   = 92'd0;
        set_op(0, 1'b0, 8'd127, 23'd0);          // 1.0
        set_op(1, 1'b0, 8'd127, 23'h400000);     // 1.5
        set_op(2, 1'b0, 8'h80,  23'd0);          // 2.0
        set_op(3, 1'b0, 8'h81,  23'h200000);     // 5.0
        req_sign = nxt_sign;
        req_exp  = nxt_exp;
        req_man  = nxt_man;

        // Pin the reference model with hand-computed values
        chk("model_2p0", 64'(rcp_ref(1'b0, 8'h80, 23'd0)), 64'h7E0000000);
        chk("model_1p5", 64'(rcp_ref(1'b0, 8'd127, 23'h400000)), 64'h7E5555555);
        chk("model_5p0", 64'(rcp_ref(1'b0, 8'h81, 23'h200000)), 64'h7C9999999);

        // Reset then idle
        for (int c = 0; c < 3; c++) cyc(1'b1, 4'd0, 4'hF);
        for (int c = 0; c < 5; c++) begin
            cyc(1'b0, 4'd0, 4'hF);
            chk("idle_ready", 64'(req_ready), 64'd0);
            chk("idle_rsp", 64'(rsp_valid), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end

        // Single operation on requester 2
        cyc(1'b0, 4'b0100, 4'hF);
        chk("single_grant", 64'(req_ready), 64'h4);
        cyc(1'b0, 4'd0, 4'hF);
        chk("single_rsp", 64'(rsp_valid), 64'h4);
        chk("single_x", 64'(rsp_x), 64'h7E0000000);

        // Round-robin from a freshly reset pointer
        cyc(1'b1, 4'd0, 4'hF);
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 4'hF, 4'hF);
            chk("rr_grant", 64'(req_ready), 64'(4'd1 << (c % 4)));
            if (c > 0) chk("rr_rsp", 64'(rsp_valid), 64'(4'd1 << ((c - 1) % 4)));
        end

        // Backpressure: requester 1 result held while requester 3 waits
        cyc(1'b0, 4'b0010, 4'hF);
        chk("bp_grant1", 64'(req_ready), 64'h2);
        chk("bp_rr_tail", 64'(rsp_valid), 64'h8);
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 4'b1000, 4'b1101);
            chk("bp_nogrant", 64'(req_ready), 64'h0);
            chk("bp_stall", 64'(dut.stall_s), 64'h1);
            chk("bp_rsp", 64'(rsp_valid), 64'h2);
            chk("bp_x", 64'(rsp_x), 64'h7E5555555);
            if (c > 0) chk("bp_x_stable", 64'(rsp_x), 64'(held_x));
            held_x = rsp_x;
        end
        cyc(1'b0, 4'b1000, 4'hF);
        chk("bp_release_grant", 64'(req_ready), 64'h8);
        chk("bp_release_rsp", 64'(rsp_valid), 64'h2);
`ifdef FLOAT_RCP_SHARE_PERF_EN
        chk("perf_issue_lit", 64'(perf_issue), 64'd9);
        chk("perf_stall_lit", 64'(perf_stall), 64'd3);
        chk("perf_conflict_lit", 64'(perf_conflict), 64'd8);
`endif
        cyc(1'b0, 4'd0, 4'hF);
        chk("bp_rsp3", 64'(rsp_valid), 64'h8);
        chk("bp_x3", 64'(rsp_x), 64'h7C9999999);

        // Reset mid-flight with the pointer away from zero
        cyc(1'b0, 4'b0010, 4'hF);
        cyc(1'b0, 4'b0001, 4'hF);
        chk("mid_grant0", 64'(req_ready), 64'h1);
        cyc(1'b1, 4'd0, 4'hF);
        chk("mid_rst_rsp", 64'(rsp_valid), 64'h0);
        cyc(1'b0, 4'd0, 4'hF);
        chk("mid_post_rsp", 64'(rsp_valid), 64'h0);
        chk("mid_post_busy", 64'(busy), 64'h0);
        chk("mid_rr_ptr", 64'(dut.rr_ptr_q), 64'h0);
        cyc(1'b0, 4'hF, 4'hF);
        chk("mid_first_grant", 64'(req_ready), 64'h1);
        for (int c = 0; c < 3; c++) cyc(1'b0, 4'd0, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
